// File: rtl/mfe_led7seg_74hc595_scan_pkg.sv
// Shared types and constants for the 74HC595 seven-segment scanner.
// Segment bytes are active low: bit7 = dp, bits 6..0 = g..a.
package mfe_led7seg_pkg;

    localparam int WORD_W = 16;

    localparam logic [7:0] SEG_0     = 8'hC0;
    localparam logic [7:0] SEG_1     = 8'hF9;
    localparam logic [7:0] SEG_2     = 8'hA4;
    localparam logic [7:0] SEG_3     = 8'hB0;
    localparam logic [7:0] SEG_4     = 8'h99;
    localparam logic [7:0] SEG_5     = 8'h92;
    localparam logic [7:0] SEG_6     = 8'h82;
    localparam logic [7:0] SEG_7     = 8'hF8;
    localparam logic [7:0] SEG_8     = 8'h80;
    localparam logic [7:0] SEG_9     = 8'h90;
    localparam logic [7:0] SEG_A     = 8'h88;
    localparam logic [7:0] SEG_B     = 8'h83;
    localparam logic [7:0] SEG_C     = 8'hC6;
    localparam logic [7:0] SEG_D     = 8'hA1;
    localparam logic [7:0] SEG_E     = 8'h86;
    localparam logic [7:0] SEG_F     = 8'h8E;
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    typedef enum logic [2:0] {
        SH_IDLE,
        SH_LOAD,
        SH_SHIFT_LO,
        SH_SHIFT_HI,
        SH_LATCH
    } sh_state_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_HOLD
    } scan_state_t;

    function automatic logic [7:0] hex_to_seg(input logic [3:0] nib);
        case (nib)
            4'h0: return SEG_0;
            4'h1: return SEG_1;
            4'h2: return SEG_2;
            4'h3: return SEG_3;
            4'h4: return SEG_4;
            4'h5: return SEG_5;
            4'h6: return SEG_6;
            4'h7: return SEG_7;
            4'h8: return SEG_8;
            4'h9: return SEG_9;
            4'hA: return SEG_A;
            4'hB: return SEG_B;
            4'hC: return SEG_C;
            4'hD: return SEG_D;
            4'hE: return SEG_E;
            default: return SEG_F;
        endcase
    endfunction

endpackage

// File: rtl/mfe_led7seg_74hc595_scan_if.sv
// Display update port: packed hex nibbles plus per-digit dp/blank masks, valid/ready.
interface mfe_led7seg_74hc595_scan_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] upd_val;
    logic [NUM_DIGITS-1:0]   upd_dp;
    logic [NUM_DIGITS-1:0]   upd_blank;
    logic                    upd_vld;
    logic                    upd_rdy;

    modport master (output upd_val, upd_dp, upd_blank, upd_vld, input upd_rdy);
    modport slave  (input upd_val, upd_dp, upd_blank, upd_vld, output upd_rdy);
endinterface

// File: rtl/mfe_led7seg_74hc595_shifter.sv
// 16-bit MSB-first serializer for a 74HC595 chain, followed by a storage-clock pulse.
//   state       | meaning
//   SH_IDLE     | waiting for start, all outputs low
//   SH_LOAD     | one cycle: capture word, present bit 15 on dio
//   SH_SHIFT_LO | sclk low for CLK_DIV cycles, dio stable
//   SH_SHIFT_HI | sclk high for CLK_DIV cycles, next bit on exit
//   SH_LATCH    | rclk high for CLK_DIV cycles; done on the last one
module mfe_led7seg_74hc595_shifter
    import mfe_led7seg_pkg::*;
#(
    parameter int CLK_DIV = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic [WORD_W-1:0] i_word,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_sclk,
    output logic              o_rclk,
    output logic              o_dio
);
    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LOAD = DIV_W'(CLK_DIV - 1);

    sh_state_t         r_state, w_state_nxt;
    logic [DIV_W-1:0]  r_div;
    logic [3:0]        r_bit;
    logic [WORD_W-1:0] r_shift;
    logic              r_sclk, r_rclk, r_dio;
    logic              w_div_tc, w_bit_tc, w_done;

    assign w_div_tc = (r_div == '0);
    assign w_bit_tc = (r_bit == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_done      = 1'b0;
        case (r_state)
            SH_IDLE:     if (i_start) w_state_nxt = SH_LOAD;
            SH_LOAD:     w_state_nxt = SH_SHIFT_LO;
            SH_SHIFT_LO: if (w_div_tc) w_state_nxt = SH_SHIFT_HI;
            SH_SHIFT_HI: if (w_div_tc) w_state_nxt = w_bit_tc ? SH_LATCH : SH_SHIFT_LO;
            SH_LATCH: begin
                if (w_div_tc) begin
                    w_done      = 1'b1;
                    // back-to-back words chain straight into LOAD with no idle gap
                    w_state_nxt = i_start ? SH_LOAD : SH_IDLE;
                end
            end
            default:     w_state_nxt = SH_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= SH_IDLE;
            r_div   <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_sclk  <= 1'b0;
            r_rclk  <= 1'b0;
            r_dio   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_sclk  <= (w_state_nxt == SH_SHIFT_HI);
            r_rclk  <= (w_state_nxt == SH_LATCH);
            if (w_state_nxt != r_state) r_div <= DIV_LOAD;
            else if (!w_div_tc)         r_div <= r_div - 1'b1;
            case (r_state)
                SH_LOAD: begin
                    r_shift <= i_word;
                    r_dio   <= i_word[WORD_W-1];
                    r_bit   <= 4'(WORD_W - 1);
                end
                SH_SHIFT_HI: begin
                    if (w_div_tc && !w_bit_tc) begin
                        r_shift <= {r_shift[WORD_W-2:0], 1'b0};
                        r_dio   <= r_shift[WORD_W-2];
                        r_bit   <= r_bit - 1'b1;
                    end
                end
                SH_LATCH: if (w_state_nxt == SH_IDLE) r_dio <= 1'b0;
                default: ;
            endcase
        end
    end

    assign o_busy = (r_state != SH_IDLE);
    assign o_done = w_done;
    assign o_sclk = r_sclk;
    assign o_rclk = r_rclk;
    assign o_dio  = r_dio;
endmodule

// File: rtl/mfe_led7seg_74hc595_scan.sv
// Multiplexed 1..8 digit scanner: update handshake, frame-aligned shadow regs, decode, digit/hold timing.
//   state   | meaning
//   ST_IDLE | scan stopped, pending update applied immediately
//   ST_RUN  | shifter is serializing/latching the current digit
//   ST_HOLD | DIGIT_HOLD idle cycles after the latch
module mfe_led7seg_74hc595_scan
    import mfe_led7seg_pkg::*;
#(
    parameter int NUM_DIGITS = 8,
    parameter int CLK_DIV    = 4,
    parameter int DIGIT_HOLD = 0
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    mfe_led7seg_74hc595_scan_if.slave      upd,
    input  logic                           i_en,
    output logic                           o_frame_done,
    output logic                           o_sclk,
    output logic                           o_rclk,
    output logic                           o_dio
);
    localparam int         HOLD_W   = (DIGIT_HOLD > 1) ? $clog2(DIGIT_HOLD) : 1;
    localparam logic [2:0] LAST_DIG = 3'(NUM_DIGITS - 1);

    scan_state_t             r_state, w_state_nxt;
    logic [2:0]              r_digit, w_digit_nxt;
    logic [HOLD_W-1:0]       r_hold;
    logic [4*NUM_DIGITS-1:0] r_pend_val, r_shad_val;
    logic [NUM_DIGITS-1:0]   r_pend_dp, r_pend_blank, r_shad_dp, r_shad_blank;
    logic                    r_rdy, r_frame_done;
    logic                    w_start, w_word_end, w_wrap, w_boundary, w_accept;
    logic                    w_sh_busy, w_sh_done;
    logic [3:0]              w_nib;
    logic                    w_dp, w_blank;
    logic [7:0]              w_seg, w_sel;
    logic [WORD_W-1:0]       w_word;

    always_comb begin
        w_nib   = '0;
        w_dp    = 1'b0;
        w_blank = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (r_digit == 3'(i)) begin
                w_nib   = r_shad_val[4*i +: 4];
                w_dp    = r_shad_dp[i];
                w_blank = r_shad_blank[i];
            end
        end
        w_seg = hex_to_seg(w_nib);
        if (w_dp)    w_seg[7] = 1'b0;
        if (w_blank) w_seg    = SEG_BLANK;
        w_sel = 8'b1 << r_digit;
    end

    assign w_word      = {w_seg, w_sel};
    assign w_wrap      = (r_digit == LAST_DIG);
    assign w_digit_nxt = w_wrap ? 3'd0 : r_digit + 3'd1;

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_word_end  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (i_en && !w_sh_busy) begin
                    w_start     = 1'b1;
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_sh_done) begin
                    if (DIGIT_HOLD == 0) w_word_end  = 1'b1;
                    else                 w_state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: if (r_hold == '0) w_word_end = 1'b1;
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_word_end) begin
            if (i_en) begin
                w_start     = 1'b1;
                w_state_nxt = ST_RUN;
            end else begin
                w_state_nxt = ST_IDLE;
            end
        end
    end

    // frame boundary: digit 0 about to load, or scanning stopped
    assign w_boundary = (r_state == ST_IDLE) || (w_word_end && w_wrap);
    assign w_accept   = upd.upd_vld && r_rdy;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state      <= ST_IDLE;
            r_digit      <= '0;
            r_hold       <= '0;
            r_pend_val   <= '0;
            r_pend_dp    <= '0;
            r_pend_blank <= '0;
            r_shad_val   <= '0;
            r_shad_dp    <= '0;
            r_shad_blank <= '1;
            r_rdy        <= 1'b1;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_frame_done <= w_word_end && w_wrap;
            if (w_word_end) r_digit <= w_digit_nxt;
            if (r_state == ST_RUN && w_sh_done) r_hold <= HOLD_W'(DIGIT_HOLD - 1);
            else if (r_hold != '0)              r_hold <= r_hold - 1'b1;
            if (w_accept) begin
                r_pend_val   <= upd.upd_val;
                r_pend_dp    <= upd.upd_dp;
                r_pend_blank <= upd.upd_blank;
                r_rdy        <= 1'b0;
            end else if (!r_rdy && w_boundary) begin
                r_shad_val   <= r_pend_val;
                r_shad_dp    <= r_pend_dp;
                r_shad_blank <= r_pend_blank;
                r_rdy        <= 1'b1;
            end
        end
    end

    mfe_led7seg_74hc595_shifter #(
        .CLK_DIV (CLK_DIV)
    ) u_shifter (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (w_start),
        .i_word  (w_word),
        .o_busy  (w_sh_busy),
        .o_done  (w_sh_done),
        .o_sclk  (o_sclk),
        .o_rclk  (o_rclk),
        .o_dio   (o_dio)
    );

    assign upd.upd_rdy  = r_rdy;
    assign o_frame_done = r_frame_done;
endmodule

// File: tb/tb_mfe_led7seg_74hc595_scan.sv
// Directed bench: decodes the serial stream back into latched words and checks content and timing.
module tb_mfe_led7seg_74hc595_scan;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int checks = 0;
    int errors = 0;

    logic rst_a, en_a, fd_a, sclk_a, rclk_a, dio_a;
    logic rst_m3, en_m3, fd_m3, sclk_m3, rclk_m3, dio_m3;

    mfe_led7seg_74hc595_scan_if #(.NUM_DIGITS(8)) upd_a ();
    mfe_led7seg_74hc595_scan_if #(.NUM_DIGITS(3)) upd_m3 ();

    mfe_led7seg_74hc595_scan #(.NUM_DIGITS(8), .CLK_DIV(2), .DIGIT_HOLD(0)) dut_a (
        .i_clk(clk), .i_rst(rst_a), .upd(upd_a), .i_en(en_a),
        .o_frame_done(fd_a), .o_sclk(sclk_a), .o_rclk(rclk_a), .o_dio(dio_a)
    );

    mfe_led7seg_74hc595_scan #(.NUM_DIGITS(3), .CLK_DIV(2), .DIGIT_HOLD(10)) dut_m3 (
        .i_clk(clk), .i_rst(rst_m3), .upd(upd_m3), .i_en(en_m3),
        .o_frame_done(fd_m3), .o_sclk(sclk_m3), .o_rclk(rclk_m3), .o_dio(dio_m3)
    );

    // Serial-stream monitors: shift dio on sclk rise, record word and cycle on rclk rise.
    logic [15:0] sh_a = '0, sh_m3 = '0;
    logic        ps_a = 1'b0, pr_a = 1'b0, ps_m3 = 1'b0, pr_m3 = 1'b0;
    logic [15:0] wq_a[$], wq_m3[$];
    int          tq_a[$], tq_m3[$], fq_a[$], fq_m3[$];

    always @(negedge clk) begin
        if (sclk_a === 1'b1 && !ps_a) sh_a = {sh_a[14:0], dio_a};
        if (rclk_a === 1'b1 && !pr_a) begin wq_a.push_back(sh_a); tq_a.push_back(cyc); end
        if (fd_a === 1'b1) fq_a.push_back(cyc);
        ps_a = (sclk_a === 1'b1);
        pr_a = (rclk_a === 1'b1);
    end

    always @(negedge clk) begin
        if (sclk_m3 === 1'b1 && !ps_m3) sh_m3 = {sh_m3[14:0], dio_m3};
        if (rclk_m3 === 1'b1 && !pr_m3) begin wq_m3.push_back(sh_m3); tq_m3.push_back(cyc); end
        if (fd_m3 === 1'b1) fq_m3.push_back(cyc);
        ps_m3 = (sclk_m3 === 1'b1);
        pr_m3 = (rclk_m3 === 1'b1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic get_a(output logic [15:0] w, output int t);
        int n = 0;
        while (wq_a.size() == 0 && n < 300) begin @(negedge clk); #1; n++; end
        if (wq_a.size() == 0) begin
            checks++; errors++;
            $error("FAIL word_timeout_a observed=none expected=latched_word");
            w = 'x; t = -1;
        end else begin
            w = wq_a.pop_front(); t = tq_a.pop_front();
        end
    endtask

    task automatic get_m3(output logic [15:0] w, output int t);
        int n = 0;
        while (wq_m3.size() == 0 && n < 300) begin @(negedge clk); #1; n++; end
        if (wq_m3.size() == 0) begin
            checks++; errors++;
            $error("FAIL word_timeout_m3 observed=none expected=latched_word");
            w = 'x; t = -1;
        end else begin
            w = wq_m3.pop_front(); t = tq_m3.pop_front();
        end
    endtask

    task automatic send_a(input logic [31:0] v, input logic [7:0] dp, input logic [7:0] bl);
        upd_a.upd_val = v; upd_a.upd_dp = dp; upd_a.upd_blank = bl; upd_a.upd_vld = 1'b1;
        @(negedge clk); #1;
        upd_a.upd_vld = 1'b0;
    endtask

    logic [15:0] exp_f3 [8] = '{16'hC001, 16'hF902, 16'hA404, 16'hB008,
                                16'h9910, 16'h9220, 16'h8240, 16'hF880};
    logic [15:0] exp_f5 [8] = '{16'h0801, 16'hF902, 16'hA404, 16'hFF08,
                                16'h9910, 16'h9220, 16'h8240, 16'hF880};

    initial begin
        #2_000_000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] w;
        int t, t_prev, t_last, n;

        rst_a = 1'b1; en_a = 1'b0; rst_m3 = 1'b1; en_m3 = 1'b0;
        upd_a.upd_val = '0;  upd_a.upd_dp = '0;  upd_a.upd_blank = '0;  upd_a.upd_vld = 1'b0;
        upd_m3.upd_val = '0; upd_m3.upd_dp = '0; upd_m3.upd_blank = '0; upd_m3.upd_vld = 1'b0;
        t_prev = 0; t_last = 0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_sclk", 32'(sclk_a), 0);
        check("rst_rclk", 32'(rclk_a), 0);
        check("rst_dio", 32'(dio_a), 0);
        check("rst_frame_done", 32'(fd_a), 0);
        check("rst_upd_rdy", 32'(upd_a.upd_rdy), 1);

        rst_a = 1'b0; en_a = 1'b1;
        // frame 1: blank display, one-hot select
        for (int i = 0; i < 8; i++) begin
            get_a(w, t);
            check("f1_word", 32'(w), {16'h0, 8'hFF, 8'(1 << i)});
            if (i == 1) check("word_period", 32'(t - t_prev), 67);
            if (i == 7) t_last = t;
            t_prev = t;
        end

        // frame 2: update mid-frame, must not show until the next boundary
        for (int i = 0; i < 2; i++) begin
            get_a(w, t);
            check("f2_word_pre", 32'(w), {16'h0, 8'hFF, 8'(1 << i)});
        end
        send_a(32'h76543210, 8'h00, 8'h00);
        check("rdy_low_after_accept", 32'(upd_a.upd_rdy), 0);
        send_a(32'hFFFFFFFF, 8'hFF, 8'hFF);
        for (int i = 2; i < 8; i++) begin
            get_a(w, t);
            check("f2_word_post", 32'(w), {16'h0, 8'hFF, 8'(1 << i)});
        end
        check("rdy_low_until_boundary", 32'(upd_a.upd_rdy), 0);

        // frame 3: new data
        for (int i = 0; i < 8; i++) begin
            get_a(w, t);
            check("f3_word", 32'(w), 32'(exp_f3[i]));
            if (i == 0) check("rdy_high_after_boundary", 32'(upd_a.upd_rdy), 1);
        end
        check("frame_done_count", 32'(fq_a.size()), 2);
        if (fq_a.size() >= 2) begin
            check("frame_done_after_latch", 32'(fq_a[0] - t_last), 2);
            check("frame_period", 32'(fq_a[1] - fq_a[0]), 536);
        end

        // frame 4: dp and blank masks, applied at frame 5
        for (int i = 0; i < 3; i++) begin
            get_a(w, t);
            check("f4_word_pre", 32'(w), 32'(exp_f3[i]));
        end
        send_a(32'h7654321A, 8'h01, 8'h08);
        for (int i = 3; i < 8; i++) begin
            get_a(w, t);
            check("f4_word_post", 32'(w), 32'(exp_f3[i]));
        end
        for (int i = 0; i < 8; i++) begin
            get_a(w, t);
            check("f5_word", 32'(w), 32'(exp_f5[i]));
        end

        // drop en in the middle of digit 2: word completes, then idle, resume at digit 3
        for (int i = 0; i < 2; i++) begin
            get_a(w, t);
            check("f6_word", 32'(w), 32'(exp_f5[i]));
        end
        repeat (44) @(negedge clk);
        #1;
        en_a = 1'b0;
        get_a(w, t);
        check("en_off_word_completes", 32'(w), 32'(exp_f5[2]));
        repeat (3) @(negedge clk);
        #1;
        check("idle_sclk", 32'(sclk_a), 0);
        check("idle_rclk", 32'(rclk_a), 0);
        check("idle_dio", 32'(dio_a), 0);
        repeat (100) @(negedge clk);
        #1;
        check("idle_no_words", 32'(wq_a.size()), 0);
        en_a = 1'b1;
        get_a(w, t);
        check("resume_digit3", 32'(w), 32'(exp_f5[3]));

        // reset in SHIFT_HI with a pending update
        send_a(32'h88888888, 8'h00, 8'h00);
        check("pending_before_rst", 32'(upd_a.upd_rdy), 0);
        n = 0;
        while (sclk_a !== 1'b1 && n < 200) begin @(negedge clk); #1; n++; end
        check("sclk_high_seen", 32'(sclk_a), 1);
        rst_a = 1'b1;
        @(negedge clk);
        #1;
        rst_a = 1'b0;
        check("midrst_sclk", 32'(sclk_a), 0);
        check("midrst_rclk", 32'(rclk_a), 0);
        check("midrst_dio", 32'(dio_a), 0);
        check("midrst_upd_rdy", 32'(upd_a.upd_rdy), 1);
        get_a(w, t);
        check("post_rst_word0", 32'(w), 32'h0000FF01);
        get_a(w, t);
        check("post_rst_word1", 32'(w), 32'h0000FF02);

        // 3 digits with 10 hold cycles
        rst_m3 = 1'b0; en_m3 = 1'b1;
        for (int i = 0; i < 7; i++) begin
            get_m3(w, t);
            check("m3_word", 32'(w), {16'h0, 8'hFF, 8'(1 << (i % 3))});
            if (i == 1) check("m3_word_period", 32'(t - t_prev), 77);
            if (i == 2) t_last = t;
            t_prev = t;
        end
        check("m3_frame_done_count", 32'(fq_m3.size()), 2);
        if (fq_m3.size() >= 2) begin
            check("m3_frame_done_after_hold", 32'(fq_m3[0] - t_last), 12);
            check("m3_frame_period", 32'(fq_m3[1] - fq_m3[0]), 231);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mfe_led7seg_74hc595_scan.md
Name: mfe_led7seg_74hc595_scan

Overview:
Parametrised successor to the fixed-pattern 74HC595 7-seg demo/controller pair. It accepts a packed hex value plus per-digit decimal-point and blanking masks through a valid/ready update port. It decodes each nibble to segments and continuously scans 1..8 digits over a two-byte 74HC595 chain (segment byte, then select byte). Updates are applied only at frame boundaries, so the display never tears.

Parameters:
NUM_DIGITS, 8, number of scanned digits; legal range 1..8.
CLK_DIV, 4, clk cycles per sclk half-period and rclk pulse width; legal values ≥1.
DIGIT_HOLD, 0, extra idle clk cycles after each latch, used as a brightness/refresh trim; legal values ≥0.

Ports:
clk  in  1  system clock; single clock domain.
rst  in  1  synchronous, active-high reset.
upd_val  in  4*NUM_DIGITS  hex nibbles; nibble i drives digit i.
upd_dp  in  NUM_DIGITS  1 = decimal point on for digit i.
upd_blank  in  NUM_DIGITS  1 = digit i is dark (segments all off, dp off).
upd_vld  in  1  update request.
upd_rdy  out  1  update accepted when upd_vld && upd_rdy.
en  in  1  scan enable.
frame_done  out  1  one-cycle pulse after the last digit's latch/hold completes.
sclk  out  1  74HC595 shift clock.
rclk  out  1  74HC595 storage (latch) clock.
dio  out  1  serial data, MSB first.

Behaviour:
- Reset values: sclk=0, rclk=0, dio=0, frame_done=0, upd_rdy=1, digit index=0, FSM=IDLE. Shadow regs: val=0, dp=0, blank=all ones, so the display is blank after reset.
- Update handshake:
  - On upd_vld && upd_rdy, capture the inputs into a pending buffer and drop upd_rdy the next cycle.
  - At the next frame boundary (digit index 0 entering LOAD, or IDLE), copy pending→shadow and raise upd_rdy the next cycle.
  - Inputs are ignored while upd_rdy=0.
- Segment decode (active low, bit7=dp, bits6..0=g..a):
  - 0:C0 1:F9 2:A4 3:B0 4:99 5:92 6:82 7:F8 8:80 9:90 A:88 b:83 C:C6 d:A1 E:86 F:8E.
  - dp=1 clears bit7.
  - blank=1 forces FF regardless of dp.
- Select byte: one-hot, bit i high for digit i, upper bits 0.
- Word = {seg[7:0], sel[7:0]}, shifted bit15 first.
- FSM states and transitions:
  - IDLE: leave when en=1; go to LOAD.
  - LOAD: 1 cycle; build the word for the current digit; dio<=bit15.
  - SHIFT_LO: sclk=0 for CLK_DIV cycles; dio is valid throughout.
  - SHIFT_HI: sclk=1 for CLK_DIV cycles. On exit, set dio to the next bit and return to SHIFT_LO; after bit 0, go to LATCH.
  - LATCH: rclk=1, sclk=0 for CLK_DIV cycles.
  - HOLD: DIGIT_HOLD cycles (skipped when 0). On exit, advance the digit index, wrapping NUM_DIGITS-1→0.
  - On wrap, frame_done pulses 1 cycle, then go to LOAD if en=1, else IDLE.
- Word period = 1 + 32*CLK_DIV + CLK_DIV + DIGIT_HOLD clk cycles. Frame period = NUM_DIGITS × word period.
- Handling en: en=0 mid-word completes the current word and its latch/hold, then goes to IDLE; it never truncates a word. The digit index is preserved, and resume starts at the next digit.
- IDLE outputs: sclk=0, rclk=0, dio=0.
- Simultaneous events: if upd_vld is accepted in the same cycle the frame boundary is taken, the pending buffer is applied at the following boundary (one-frame latency worst case two frames).
- Reset mid-word: all outputs return to reset values the next cycle; the pending update is discarded.

Decomposition:
- Shared package mfe_led7seg_pkg:
  - hex→segment table constants (SEG_0..SEG_F, SEG_BLANK=8'hFF);
  - WORD_W=16;
  - FSM state encoding.
- Sub-module mfe_led7seg_74hc595_shifter: 16-bit serializer with start/word in, busy/done out, CLK_DIV param. It implements the LOAD/SHIFT/LATCH states.
- The top level owns the handshake, shadow/pending registers, decode, digit counter and HOLD.

Test Plan:
1. Reset, NUM_DIGITS=8, CLK_DIV=2, DIGIT_HOLD=0, en=1 → first word = FF01 (blank, digit 0); word period 67 cycles, frame_done every 536 cycles.
2. Update upd_val=32'h76543210, dp=0, blank=0 mid-frame → words unchanged until the next boundary, then C001, F902, A404, B008, 9910, 9220, 8240, F880. upd_rdy low only until that boundary.
3. upd_val nibble 0 = 4'hA, dp[0]=1, blank[3]=1 → word 0 = 0801, word 3 = FF08.
4. Deassert en during bit 5 of digit 2 → that word finishes with the rclk pulse, then sclk=rclk=dio=0. Re-enable → next word selects digit 3 (sel=08).
5. NUM_DIGITS=3, DIGIT_HOLD=10 → sel sequence 01,02,04,01…; word period 1+64+2+10=77 cycles; frame_done every 231 cycles.
6. Assert rst during SHIFT_HI with a pending update → sclk=0, upd_rdy=1 the next cycle; the pending data is never displayed and the display restarts blank at digit 0.
